traffic_lights_cmd_master: RTL and testbench

- Command initiator for the traffic light controller.
- Accepts high-level requests from a host or test sequencer: CONFIG (load times), ON, OFF and BLINK.
- Converts each request into the controller's single-cycle command stream (cmd_type/cmd_val/cmd_data).
- Sequences the mandatory ordering itself: the controller accepts time writes only in yellow-blink, so CONFIG forces blink first, then writes the times, then restarts at red.

---
 rtl/traffic_lights_cmd_master_if.sv | 28 ++
 rtl/traffic_lights_cmd_master.sv | 188 ++++++++++++++++++
 tb/tb_traffic_lights_cmd_master.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_lights_cmd_master_if.sv
// Request/command bundle between a host sequencer, the command master and the
// traffic light controller. The master modport is the command master's view.
`timescale 1us/1ns

interface traffic_lights_cmd_master_if;
    logic [1:0]  req_type_i;
    logic [15:0] req_red_ms_i;
    logic [15:0] req_yellow_ms_i;
    logic [15:0] req_green_ms_i;
    logic        req_val_i;
    logic        req_ready_o;
    logic [2:0]  cmd_type_o;
    logic        cmd_val_o;
    logic [15:0] cmd_data_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    modport master (
        input  req_type_i, req_red_ms_i, req_yellow_ms_i, req_green_ms_i, req_val_i,
        output req_ready_o, cmd_type_o, cmd_val_o, cmd_data_o, busy_o, done_o, err_o
    );

    modport slave (
        output req_type_i, req_red_ms_i, req_yellow_ms_i, req_green_ms_i, req_val_i,
        input  req_ready_o, cmd_type_o, cmd_val_o, cmd_data_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/traffic_lights_cmd_master.sv
// Turns host requests (CONFIG/ON/OFF/BLINK) into the traffic light controller's
// single-cycle command stream, spacing commands by CMD_GAP_CLK idle clocks.
`timescale 1us/1ns

module traffic_lights_cmd_master #(
    parameter int CMD_GAP_CLK = 2,
    parameter int MAX_TIME_MS = 16383
) (
    input logic                           clk_0m002,
    input logic                           arst_n_i,
    traffic_lights_cmd_master_if.master   bus
);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SEND, S_GAP} state_t;

    typedef struct packed {
        logic [2:0]  ctype;
        logic [15:0] data;
    } cmd_t;

    localparam logic [1:0] REQ_CONFIG = 2'd0;
    localparam logic [1:0] REQ_ON     = 2'd1;
    localparam logic [1:0] REQ_OFF    = 2'd2;

    localparam logic [2:0] CMD_ON     = 3'd0;
    localparam logic [2:0] CMD_OFF    = 3'd1;
    localparam logic [2:0] CMD_BLINK  = 3'd2;
    localparam logic [2:0] CMD_GREEN  = 3'd3;
    localparam logic [2:0] CMD_RED    = 3'd4;
    localparam logic [2:0] CMD_YELLOW = 3'd5;

    localparam bit          NO_GAP     = (CMD_GAP_CLK == 0);
    localparam logic [7:0]  GAP_RELOAD = NO_GAP ? 8'd0 : 8'(CMD_GAP_CLK - 1);
    localparam logic [15:0] MAX_T      = 16'(MAX_TIME_MS);

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_idx, w_idx_nxt;
    logic [7:0]  r_gap;
    logic [1:0]  r_req_type;
    logic [15:0] r_red, r_yellow, r_green;
    logic        r_ready, r_busy, r_done, r_cmd_val;
    logic [2:0]  r_cmd_type;
    logic [15:0] r_cmd_data;

    logic        w_accept, w_bad, w_last, w_err;
    logic        w_ready, w_busy, w_done, w_cmd_val;
    logic [2:0]  w_cmd_type;
    logic [15:0] w_cmd_data;
    cmd_t        w_cmd;

    function automatic logic [2:0] last_idx(input logic [1:0] rt);
        return (rt == REQ_CONFIG) ? 3'd4 : 3'd0;
    endfunction

    function automatic cmd_t cmd_lookup(input logic [1:0] rt, input logic [2:0] idx,
                                        input logic [15:0] red, input logic [15:0] yel,
                                        input logic [15:0] grn);
        cmd_t c;
        c.ctype = CMD_ON;
        c.data  = '0;
        case (rt)
            REQ_CONFIG: begin
                case (idx)
                    3'd0:    c.ctype = CMD_BLINK;
                    3'd1:    begin c.ctype = CMD_GREEN;  c.data = grn; end
                    3'd2:    begin c.ctype = CMD_RED;    c.data = red; end
                    3'd3:    begin c.ctype = CMD_YELLOW; c.data = yel; end
                    default: c.ctype = CMD_ON;
                endcase
            end
            REQ_ON:  c.ctype = CMD_ON;
            REQ_OFF: c.ctype = CMD_OFF;
            default: c.ctype = CMD_BLINK;
        endcase
        return c;
    endfunction

    function automatic logic time_bad(input logic [15:0] t);
        return (t == 16'd0) || (t > MAX_T);
    endfunction

    assign w_accept = bus.req_val_i & r_ready;
    assign w_last   = (r_idx == last_idx(r_req_type));
    assign w_bad    = (r_req_type == REQ_CONFIG) &&
                      (time_bad(r_red) || time_bad(r_yellow) || time_bad(r_green));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_CHECK;
                    w_idx_nxt   = '0;
                end
            end
            S_CHECK: w_state_nxt = w_bad ? S_IDLE : S_SEND;
            S_SEND: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_idx_nxt   = r_idx + 3'd1;
                    w_state_nxt = NO_GAP ? S_SEND : S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == 8'd0) w_state_nxt = S_SEND;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead from the next state so they can be
    // registered; err is decoded from the CHECK state and the latched fields.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        w_cmd      = cmd_lookup(r_req_type, w_idx_nxt, r_red, r_yellow, r_green);
        w_cmd_val  = (w_state_nxt == S_SEND);
        w_cmd_type = '0;
        w_cmd_data = '0;
        if (w_cmd_val) begin
            w_cmd_type = w_cmd.ctype;
            w_cmd_data = w_cmd.data;
        end
        w_done  = w_cmd_val && (w_idx_nxt == last_idx(r_req_type));
        w_busy  = (w_state_nxt != S_IDLE);
        w_ready = (w_state_nxt == S_IDLE);
        w_err   = (r_state == S_CHECK) && w_bad;
    end

    always_ff @(posedge clk_0m002 or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cmd_val  <= 1'b0;
            r_cmd_type <= '0;
            r_cmd_data <= '0;
            r_gap      <= '0;
            r_req_type <= '0;
            r_red      <= '0;
            r_yellow   <= '0;
            r_green    <= '0;
        end else begin
            r_ready    <= w_ready;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_cmd_val  <= w_cmd_val;
            r_cmd_type <= w_cmd_type;
            r_cmd_data <= w_cmd_data;

            case (r_state)
                S_IDLE:  r_gap <= '0;
                S_SEND:  r_gap <= GAP_RELOAD;
                S_GAP:   if (r_gap != 8'd0) r_gap <= r_gap - 8'd1;
                default: r_gap <= r_gap;
            endcase

            if (w_accept) begin
                r_req_type <= bus.req_type_i;
                r_red      <= bus.req_red_ms_i;
                r_yellow   <= bus.req_yellow_ms_i;
                r_green    <= bus.req_green_ms_i;
            end
        end
    end

    assign bus.req_ready_o = r_ready;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.cmd_val_o   = r_cmd_val;
    assign bus.cmd_type_o  = r_cmd_type;
    assign bus.cmd_data_o  = r_cmd_data;
    assign bus.err_o       = w_err;

endmodule

// File: tb/tb_traffic_lights_cmd_master.sv
// Directed bench for traffic_lights_cmd_master: one instance with a 2-clock
// command gap, one with no gap. Cycle 0 is the cycle the request is accepted in.
`timescale 1us/1ns

module tb_traffic_lights_cmd_master;

    logic clk_0m002 = 1'b0;
    logic arst_n_i  = 1'b0;

    traffic_lights_cmd_master_if if_g2();
    traffic_lights_cmd_master_if if_g0();

    traffic_lights_cmd_master #(.CMD_GAP_CLK(2), .MAX_TIME_MS(16383)) u_dut_g2 (
        .clk_0m002 (clk_0m002),
        .arst_n_i  (arst_n_i),
        .bus       (if_g2.master)
    );

    traffic_lights_cmd_master #(.CMD_GAP_CLK(0), .MAX_TIME_MS(16383)) u_dut_g0 (
        .clk_0m002 (clk_0m002),
        .arst_n_i  (arst_n_i),
        .bus       (if_g0.master)
    );

    always #250 clk_0m002 = ~clk_0m002;

    int n_vec = 0;
    int n_err = 0;

    // Observed/expected vectors: {val, type[3], data[16], done, busy, ready, err}
    function automatic logic [23:0] obs_g2();
        return {if_g2.cmd_val_o, if_g2.cmd_type_o, if_g2.cmd_data_o,
                if_g2.done_o, if_g2.busy_o, if_g2.req_ready_o, if_g2.err_o};
    endfunction

    function automatic logic [23:0] obs_g0();
        return {if_g0.cmd_val_o, if_g0.cmd_type_o, if_g0.cmd_data_o,
                if_g0.done_o, if_g0.busy_o, if_g0.req_ready_o, if_g0.err_o};
    endfunction

    function automatic logic [23:0] vec(input logic v, input logic [2:0] t, input logic [15:0] d,
                                        input logic dn, input logic b, input logic r, input logic e);
        return {v, t, d, dn, b, r, e};
    endfunction

    // Presents a request on if_g2 and returns at the falling edge of cycle 0.
    task automatic req_g2(input logic [1:0] t, input logic [15:0] red,
                          input logic [15:0] yel, input logic [15:0] grn);
        int w;
        @(negedge clk_0m002);
        if_g2.req_type_i      = t;
        if_g2.req_red_ms_i    = red;
        if_g2.req_yellow_ms_i = yel;
        if_g2.req_green_ms_i  = grn;
        if_g2.req_val_i       = 1'b1;
        w = 0;
        while (!if_g2.req_ready_o && w < 50) begin
            @(negedge clk_0m002);
            w++;
        end
        n_vec++;
        if (!if_g2.req_ready_o) begin
            n_err++;
            $display("FAIL ready_timeout: req_ready_o=%b after %0d cycles, required 1", if_g2.req_ready_o, w);
        end
    endtask

    task automatic test_reset();
        #100;
        n_vec++;
        if (obs_g2() !== 24'h0) begin
            n_err++;
            $display("FAIL reset_g2: got %h required %h", obs_g2(), 24'h0);
        end
        n_vec++;
        if (obs_g0() !== 24'h0) begin
            n_err++;
            $display("FAIL reset_g0: got %h required %h", obs_g0(), 24'h0);
        end
        #500 arst_n_i = 1'b1;
        #1;
        n_vec++;
        if (if_g2.req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge: got %b required 0", if_g2.req_ready_o);
        end
        @(posedge clk_0m002);
        @(negedge clk_0m002);
        n_vec++;
        if (obs_g2() !== vec(0, 0, 0, 0, 0, 1, 0)) begin
            n_err++;
            $display("FAIL ready_after_reset: got %h required %h", obs_g2(), vec(0, 0, 0, 0, 0, 1, 0));
        end
    endtask

    task automatic test_config();
        logic [2:0]  typ_tab [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [15:0] dat_tab [5] = '{16'd0, 16'd15000, 16'd10000, 16'd3000, 16'd0};
        logic [23:0] exp_v;
        int k;
        req_g2(2'd0, 16'd10000, 16'd3000, 16'd15000);
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk_0m002);
            @(negedge clk_0m002);
            if (c == 1) if_g2.req_val_i = 1'b0;
            k = (c >= 2 && (c - 2) % 3 == 0 && (c - 2) / 3 < 5) ? (c - 2) / 3 : -1;
            exp_v = (k >= 0) ? vec(1, typ_tab[k], dat_tab[k], k == 4, 1, 0, 0)
                             : vec(0, 0, 0, 0, c <= 14, c >= 15, 0);
            n_vec++;
            if (obs_g2() !== exp_v) begin
                n_err++;
                $display("FAIL config c=%0d: got %h required %h", c, obs_g2(), exp_v);
            end
        end
    endtask

    task automatic test_reject();
        logic [15:0] red_tab [2] = '{16'd10000, 16'd16384};
        logic [15:0] yel_tab [2] = '{16'd0, 16'd3000};
        logic [23:0] exp_v;
        for (int i = 0; i < 2; i++) begin
            req_g2(2'd0, red_tab[i], yel_tab[i], 16'd15000);
            for (int c = 1; c <= 3; c++) begin
                @(posedge clk_0m002);
                @(negedge clk_0m002);
                if (c == 1) if_g2.req_val_i = 1'b0;
                exp_v = (c == 1) ? vec(0, 0, 0, 0, 1, 0, 1) : vec(0, 0, 0, 0, 0, 1, 0);
                n_vec++;
                if (obs_g2() !== exp_v) begin
                    n_err++;
                    $display("FAIL reject%0d c=%0d: got %h required %h", i, c, obs_g2(), exp_v);
                end
            end
        end
        // Largest legal and smallest legal values are accepted.
        req_g2(2'd0, 16'd16383, 16'd1, 16'd1);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk_0m002);
            @(negedge clk_0m002);
            if (c == 1) if_g2.req_val_i = 1'b0;
            exp_v = (c == 1) ? vec(0, 0, 0, 0, 1, 0, 0) : vec(1, 2, 0, 0, 1, 0, 0);
            n_vec++;
            if (obs_g2() !== exp_v) begin
                n_err++;
                $display("FAIL accept_max c=%0d: got %h required %h", c, obs_g2(), exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_tab [6];
        exp_tab[0] = vec(0, 0, 0, 0, 1, 0, 0);
        exp_tab[1] = vec(1, 1, 0, 1, 1, 0, 0);
        exp_tab[2] = vec(0, 0, 0, 0, 0, 1, 0);
        exp_tab[3] = vec(0, 0, 0, 0, 1, 0, 0);
        exp_tab[4] = vec(1, 2, 0, 1, 1, 0, 0);
        exp_tab[5] = vec(0, 0, 0, 0, 0, 1, 0);
        req_g2(2'd2, 16'd0, 16'd0, 16'd0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk_0m002);
            @(negedge clk_0m002);
            if (c == 1) if_g2.req_type_i = 2'd3;
            if (c == 4) if_g2.req_val_i = 1'b0;
            n_vec++;
            if (obs_g2() !== exp_tab[c-1]) begin
                n_err++;
                $display("FAIL back_to_back c=%0d: got %h required %h", c, obs_g2(), exp_tab[c-1]);
            end
        end
    endtask

    task automatic test_ignore_busy();
        logic [2:0]  typ_tab [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [15:0] dat_tab [5] = '{16'd0, 16'd3000, 16'd1000, 16'd2000, 16'd0};
        logic [23:0] exp_v;
        int k;
        req_g2(2'd0, 16'd1000, 16'd2000, 16'd3000);
        for (int c = 1; c <= 17; c++) begin
            @(posedge clk_0m002);
            @(negedge clk_0m002);
            k = (c >= 2 && (c - 2) % 3 == 0 && (c - 2) / 3 < 5) ? (c - 2) / 3 : -1;
            exp_v = (k >= 0) ? vec(1, typ_tab[k], dat_tab[k], k == 4, 1, 0, 0)
                             : vec(0, 0, 0, 0, c <= 14, c >= 15, 0);
            n_vec++;
            if (obs_g2() !== exp_v) begin
                n_err++;
                $display("FAIL ignore_busy c=%0d: got %h required %h", c, obs_g2(), exp_v);
            end
            if (c <= 12) begin
                if_g2.req_val_i       = c[0];
                if_g2.req_type_i      = 2'(c % 4);
                if_g2.req_red_ms_i    = 16'($urandom);
                if_g2.req_yellow_ms_i = 16'($urandom);
                if_g2.req_green_ms_i  = 16'($urandom);
            end else begin
                if_g2.req_val_i = 1'b0;
            end
        end
    endtask

    task automatic test_no_gap();
        logic [2:0]  typ_tab [5] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
        logic [15:0] dat_tab [5] = '{16'd0, 16'd400, 16'd200, 16'd300, 16'd0};
        logic [23:0] exp_v;
        int w;
        @(negedge clk_0m002);
        if_g0.req_type_i      = 2'd0;
        if_g0.req_red_ms_i    = 16'd200;
        if_g0.req_yellow_ms_i = 16'd300;
        if_g0.req_green_ms_i  = 16'd400;
        if_g0.req_val_i       = 1'b1;
        w = 0;
        while (!if_g0.req_ready_o && w < 50) begin
            @(negedge clk_0m002);
            w++;
        end
        n_vec++;
        if (!if_g0.req_ready_o) begin
            n_err++;
            $display("FAIL ready_timeout_g0: req_ready_o=%b, required 1", if_g0.req_ready_o);
        end
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk_0m002);
            @(negedge clk_0m002);
            if (c == 1) if_g0.req_val_i = 1'b0;
            exp_v = (c >= 2 && c <= 6) ? vec(1, typ_tab[c-2], dat_tab[c-2], c == 6, 1, 0, 0)
                                       : vec(0, 0, 0, 0, c <= 6, c >= 7, 0);
            n_vec++;
            if (obs_g0() !== exp_v) begin
                n_err++;
                $display("FAIL no_gap c=%0d: got %h required %h", c, obs_g0(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        req_g2(2'd0, 16'd500, 16'd600, 16'd700);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk_0m002);
            @(negedge clk_0m002);
            if (c == 1) if_g2.req_val_i = 1'b0;
        end
        n_vec++;
        if (if_g2.busy_o !== 1'b1 || if_g2.cmd_val_o !== 1'b0) begin
            n_err++;
            $display("FAIL mid_gap: busy=%b val=%b required busy=1 val=0", if_g2.busy_o, if_g2.cmd_val_o);
        end
        #($urandom_range(20, 200)) arst_n_i = 1'b0;
        #5;
        n_vec++;
        if (obs_g2() !== 24'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h required %h", obs_g2(), 24'h0);
        end
        @(negedge clk_0m002);
        #($urandom_range(20, 200)) arst_n_i = 1'b1;
        #1;
        n_vec++;
        if (if_g2.req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL ready_at_release: got %b required 0", if_g2.req_ready_o);
        end
        @(posedge clk_0m002);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_0m002);
            n_vec++;
            if (obs_g2() !== vec(0, 0, 0, 0, 0, 1, 0)) begin
                n_err++;
                $display("FAIL after_reset c=%0d: got %h required %h", c, obs_g2(), vec(0, 0, 0, 0, 0, 1, 0));
            end
            @(posedge clk_0m002);
        end
    endtask

    initial begin
        if_g2.req_val_i = 1'b0; if_g2.req_type_i = '0;
        if_g2.req_red_ms_i = '0; if_g2.req_yellow_ms_i = '0; if_g2.req_green_ms_i = '0;
        if_g0.req_val_i = 1'b0; if_g0.req_type_i = '0;
        if_g0.req_red_ms_i = '0; if_g0.req_yellow_ms_i = '0; if_g0.req_green_ms_i = '0;
        test_reset();
        test_config();
        test_reject();
        test_back_to_back();
        test_ignore_busy();
        test_no_gap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(20000 * 500);
        $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
